// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if
//   Bundles the display scanner's upstream controls and display-side outputs.
//   The scanner module is the slave; the upstream driver or bench is the master.
//   Signals:
//     ena        : scanner enable (qualifies load and scanning)
//     load       : one-cycle strobe, data_in valid this cycle
//     data_in    : 8 hex nibbles, nibble 0 = data_in[3:0]
//     an         : digit anodes, active-low, an[i] = digit i (digit 0 rightmost)
//     seg        : cathodes, active-low, seg[0]=a ... seg[6]=g
//     frame_done : one-cycle pulse at the end of each 8-digit frame
interface seven_seg_scanner_if;
  logic        ena;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  modport master (
    output ena, load, data_in,
    input  an, seg, frame_done
  );

  modport slave (
    input  ena, load, data_in,
    output an, seg, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed driver for an 8-digit common-anode seven-segment display.
//   A prescaler produces one tick every REFRESH_DIV clocks; each tick advances
//   the digit index. A 32-bit word captured from upstream is held in a pending
//   register and only copied into the displayed word at a frame boundary (tick
//   on digit 7), so a frame never mixes digits of two words.
//
//   Parameters:
//     REFRESH_DIV : clk cycles per digit slot, 2..2^20
//   Ports:
//     clk  : clock, all state on rising edge
//     rst  : synchronous, active-high reset
//     bus  : seven_seg_scanner_if.slave (ena, load, data_in -> an, seg, frame_done)
//
//   Build option:
//     LEADING_ZERO_BLANK_EN : when defined, digits above the most significant
//                             non-zero nibble keep their anode off (digit 0 is
//                             always lit). When undefined no blanking logic exists.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic          clk,
  input  logic          rst,
  seven_seg_scanner_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Active-low gfedcba hex decode.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i is lit when it is digit 0 or any nibble from i upward is non-zero.
  function automatic logic lead_lit(input logic [31:0] w, input logic [2:0] i);
    logic [31:0] upper;
    upper = w >> {i, 2'b00};
    return (i == 3'd0) || (upper != 32'd0);
  endfunction
`endif

  logic [CNT_W-1:0] cnt_p0;
  logic [2:0]       idx_p0;
  logic [31:0]      display_p0;
  logic [31:0]      pending_p0;
  logic             pend_p0;

  logic [7:0]       an_p1;
  logic [6:0]       seg_p1;
  logic             frame_done_p1;

  logic             tick;
  logic             boundary;
  logic             capture;
  logic [3:0]       nibble;
  logic             digit_lit;

  assign tick     = bus.ena && (cnt_p0 == CNT_MAX);
  assign boundary = tick && (idx_p0 == 3'd7);
  assign capture  = bus.ena && bus.load;
  assign nibble   = display_p0[{idx_p0, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  assign digit_lit = lead_lit(display_p0, idx_p0);
`else
  assign digit_lit = 1'b1;
`endif

  // Stage p0: prescaler and digit index; both hold while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      idx_p0 <= 3'd0;
    end else if (bus.ena) begin
      if (tick) begin
        cnt_p0 <= '0;
        idx_p0 <= idx_p0 + 3'd1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  // Stage p0: word capture. A load on the boundary cycle bypasses pending so it
  // lands in the very next frame; otherwise the last load before the boundary wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      display_p0 <= 32'd0;
      pending_p0 <= 32'd0;
      pend_p0    <= 1'b0;
    end else if (boundary) begin
      if (capture) begin
        display_p0 <= bus.data_in;
      end else if (pend_p0) begin
        display_p0 <= pending_p0;
      end
      pend_p0 <= 1'b0;
    end else if (capture) begin
      pending_p0 <= bus.data_in;
      pend_p0    <= 1'b1;
    end
  end

  // Stage p1: registered anode/cathode drive and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_p1         <= 8'hFF;
      seg_p1        <= 7'h7F;
      frame_done_p1 <= 1'b0;
    end else begin
      frame_done_p1 <= boundary;
      if (bus.ena && digit_lit) begin
        an_p1 <= ~(8'b1 << idx_p0);
      end else begin
        an_p1 <= 8'hFF;
      end
      if (bus.ena) begin
        seg_p1 <= seg_decode(nibble);
      end else begin
        seg_p1 <= 7'h7F;
      end
    end
  end

  assign bus.an         = an_p1;
  assign bus.seg        = seg_p1;
  assign bus.frame_done = frame_done_p1;

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range 2..2^20.
REQ-002 clk  input  1  single clock for all logic; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ena  input  1  scanner enable; qualifies load and scanning.
REQ-005 load  input  1  one-cycle strobe; data_in valid this cycle.
REQ-006 data_in  input  32  word from upstream memory-read stage; 8 hex nibbles, nibble 0 = data_in[3:0].
REQ-007 an  output  8  digit anodes, active-low, an[i] drives digit i (digit 0 rightmost).
REQ-008 seg  output  7  cathodes, active-low, seg[0]=a ... seg[6]=g.
REQ-009 frame_done  output  1  one-cycle pulse at end of each 8-digit frame.

Function
REQ-010 Prescaler: counter 0..REFRESH_DIV-1; tick asserted in the cycle count == REFRESH_DIV-1; count then wraps to 0.
REQ-011 Digit index: 3-bit, increments on tick, wraps 7->0.
REQ-012 frame_done: 1 in the cycle after a tick with index 7 (registered), else 0.
REQ-013 Capture: load && ena writes data_in to pending register and sets pend flag; later load before boundary overwrites pending (last wins).
REQ-014 Frame boundary = tick with index 7; at boundary, if pend, display <= pending and pend cleared.
REQ-015 Load coincident with boundary: display <= data_in directly, pend cleared.
REQ-016 Display never changes except at a boundary or reset (no tearing mid-frame).
REQ-017 an/seg registered: one cycle after index change, an = ~(1<<index), seg = decode(display nibble[index]).
REQ-018 Decode (gfedcba, active-low): 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; full 0-F hex table.
REQ-019 ena low: prescaler and index hold, load ignored, an = 8'hFF, seg = 7'h7F, frame_done = 0; on ena high, scanning resumes from held count/index.
REQ-020 Exactly one an bit low at any time while ena high and not blanked.

Reset
REQ-021 rst high at a clock edge: prescaler 0, index 0, display 0, pending 0, pend 0, an 8'hFF, seg 7'h7F, frame_done 0.
REQ-022 rst dominates load and ena; reset mid-frame discards pending and display data.
REQ-023 First tick after rst release occurs REFRESH_DIV cycles later.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN defined: digit i (i>=1) has an[i] held 1 when display nibbles i..7 all zero; digit 0 always lit.
REQ-025 Macro undefined: all 8 digits lit including leading zeros; no blanking logic synthesised.

Verification (REFRESH_DIV=4)
REQ-026 rst 1 cycle, ena=1 -> an=FF, seg=7F during reset; after first tick an=FE, seg=1000000 (digit 0, value 0).
REQ-027 load data_in=0x0000_00A1 mid-frame -> current frame keeps old digits; after boundary digit0 seg=1111001, digit1 seg=0001000; with LEADING_ZERO_BLANK_EN digits 2-7 anodes stay 1, without it they show 1000000.
REQ-028 Two loads 0x1111_1111 then 0x8888_8888 in same frame -> next frame all digits seg=0000000.
REQ-029 load 0xFFFF_FFFF exactly on boundary cycle -> next frame all digits seg=0001110, frame_done pulses every 32 cycles.
REQ-030 ena low for 10 cycles mid-frame -> an=FF, index/prescaler frozen, load ignored; resume continues at same digit.
REQ-031 rst asserted with pend set -> after release display=0, pending dropped, an walks FE,FD,...,7F.
